serial_subtractor: RTL and testbench

Multi-cycle, bit-serial N-bit subtractor computing diff = x - y, one bit per clock, LSB first. It is the subtract-direction counterpart of the team's ripple adders. A single full-subtractor cell is reused each cycle with a registered borrow, trading latency for area. A start/done handshake connects it to a controlling FSM or datapath.

---
 rtl/arith_defs.sv | 9 +
 rtl/full_subtractor.sv | 12 +
 rtl/serial_subtractor.sv | 107 ++++++++++
 tb/tb_serial_subtractor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/arith_defs.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state codes
// and the default operand width.
package arith_defs;
  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell (a - b - bin), purely combinational.
// Counterpart of the full_adder cell; no state, no handshake.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial x - y, LSB first, one full-subtractor cell reused per cycle.
// start-to-done is WIDTH cycles; start is ignored while busy.
module serial_subtractor
  import arith_defs::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);
  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_xr;
  logic [WIDTH-1:0] r_yr;
  logic [WIDTH-2:0] r_acc;
  logic [WIDTH-1:0] w_acc_next;
  logic             r_brw;
  logic [CNT_W-1:0] r_cnt;
  logic             r_xmsb;
  logic             r_ymsb;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_ovf;
  logic             w_d;
  logic             w_bout;
  logic             w_capture;
  logic             w_last;

  full_subtractor u_fs (
    .a    (r_xr[0]),
    .b    (r_yr[0]),
    .bin  (r_brw),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_capture  = start & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_acc_next = {w_d, r_acc};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_SHIFT;
      S_SHIFT: if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = start ? S_SHIFT : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_SHIFT);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xr     <= '0;
      r_yr     <= '0;
      r_acc    <= '0;
      r_brw    <= 1'b0;
      r_cnt    <= '0;
      r_xmsb   <= 1'b0;
      r_ymsb   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_capture) begin
      r_xr   <= x;
      r_yr   <= y;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
      r_xmsb <= x[WIDTH-1];
      r_ymsb <= y[WIDTH-1];
    end else if (r_state == S_SHIFT) begin
      r_xr  <= r_xr >> 1;
      r_yr  <= r_yr >> 1;
      r_acc <= w_acc_next[WIDTH-1:1];
      r_brw <= w_bout;
      r_cnt <= r_cnt + CNT_W'(1);
      // Results are published only as the last bit retires.
      if (w_last) begin
        r_diff   <= w_acc_next;
        r_borrow <= w_bout;
        r_ovf    <= (r_xmsb != r_ymsb) & (w_d != r_xmsb);
      end
    end
  end

  assign diff   = r_diff;
  assign borrow = r_borrow;
  assign ovf    = r_ovf;
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized scoreboard bench for serial_subtractor: expected results are
// queued at issue time and checked by an independent done monitor.
module tb_serial_subtractor;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    logic         o;
    int           due;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;

  exp_t q[$];
  int   cyc;
  int   vectors;
  int   errors;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .x      (x),
    .y      (y),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain unsigned/signed integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] ya);
    exp_t e;
    int   sx, sy, r;
    sx  = $signed(xa);
    sy  = $signed(ya);
    r   = sx - sy;
    e.d = xa - ya;
    e.b = (xa < ya);
    e.o = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
    e.due = 0;
    return e;
  endfunction

  // Called just after a rising edge; start is seen on the following edge.
  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] ya, input bit expect_result);
    exp_t e;
    start = 1'b1;
    x     = xa;
    y     = ya;
    if (expect_result) begin
      e     = model(xa, ya);
      e.due = cyc + 1 + W;
      q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    x     = W'($urandom);
    y     = W'($urandom);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) return;
      @(posedge clk); #1;
    end
    errors++;
    $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
    q.delete();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return {1'b0, {(W-1){1'b1}}};
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy && done) begin
        errors++;
        $display("FAIL busy_done_overlap: got busy=1 done=1, expected not both");
      end
      if (done) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done=1 diff=0x%0h, expected no done", diff);
        end else begin
          exp_t e;
          e = q.pop_front();
          vectors++;
          chk("diff", 32'(diff), 32'(e.d));
          chk("borrow", 32'(borrow), 32'(e.b));
          chk("ovf", 32'(ovf), 32'(e.o));
          chk("done_cycle", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors = 0;
    errors  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    x       = '0;
    y       = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_borrow", 32'(borrow), 0);
    chk("rst_ovf", 32'(ovf), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    issue(8'h12, 8'h35, 1'b1); wait_drain();
    issue(8'h80, 8'h01, 1'b1); wait_drain();
    issue(8'h7F, 8'hFF, 1'b1); wait_drain();

    // Second start during SHIFT must be ignored.
    issue(8'h10, 8'h01, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; x = 8'hFF; y = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain();

    // Back-to-back: second start lands in the DONE cycle.
    issue(8'h44, 8'h11, 1'b1);
    repeat (W) begin @(posedge clk); #1; end
    issue(8'h00, 8'h01, 1'b1);
    chk("b2b_busy", 32'(busy), 1);
    chk("b2b_done", 32'(done), 0);
    wait_drain();

    // Idle hold after a result.
    issue(8'h35, 8'h12, 1'b1);
    wait_drain();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_diff", 32'(diff), 32'h23);
      chk("hold_borrow", 32'(borrow), 0);
      chk("hold_ovf", 32'(ovf), 0);
      chk("hold_busy", 32'(busy), 0);
      chk("hold_done", 32'(done), 0);
    end
    @(posedge clk); #1;

    // Asynchronous reset in the fourth SHIFT cycle aborts the operation.
    issue(8'h5A, 8'h33, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_diff", 32'(diff), 0);
    chk("abort_borrow", 32'(borrow), 0);
    chk("abort_ovf", 32'(ovf), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    chk("post_abort_diff", 32'(diff), 0);
    issue(8'h05, 8'h05, 1'b1);
    wait_drain();

    // Random isolated operations with corner-biased operands.
    for (int i = 0; i < 25; i++) begin
      issue(pick(), pick(), 1'b1);
      wait_drain();
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end

    // Random back-to-back chain.
    for (int i = 0; i < 6; i++) begin
      issue(pick(), pick(), 1'b1);
      if (i < 5) repeat (W) begin @(posedge clk); #1; end
    end
    wait_drain();

    // Equal operands.
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] v;
      v = W'($urandom);
      issue(v, v, 1'b1);
      wait_drain();
    end

    repeat (3) begin @(posedge clk); #1; end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
